// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation core.
package puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StFire,
        StSample,
        StDone
    } state_e;

    localparam int unsigned SYNC_STAGES = 2;

    // Width of a counter that must hold 0..repeats inclusive.
    function automatic int unsigned cnt_width(input int unsigned repeats);
        return (repeats < 1) ? 1 : $clog2(repeats + 1);
    endfunction

endpackage

// File: rtl/puf_switch_stage.sv
// One arbiter-PUF switch stage: a pair of 2:1 muxes sharing a challenge bit.
module puf_switch_stage (
    input  logic top_i,
    input  logic bot_i,
    input  logic c_i,
    output logic top_o,
    output logic bot_o
);

    // c_i=0 passes straight through, c_i=1 crosses the two paths.
    assign top_o = c_i ? bot_i : top_i;
    assign bot_o = c_i ? top_i : bot_i;

endmodule

// File: rtl/arbiter_puf_eval.sv
// Arbiter-PUF core: switch chain, arbiter latch, synchroniser and evaluation FSM.
// Define PUF_MAJORITY_VOTE_EN to evaluate each challenge REPEATS times and majority-vote.
module arbiter_puf_eval
    import puf_pkg::*;
#(
    parameter int unsigned N_STAGES      = 64,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned REPEATS       = 5,
    parameter int unsigned CNT_W         = cnt_width(REPEATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [N_STAGES-1:0] challenge_i,
    output logic                ready_o,
    output logic                resp_valid_o,
    output logic                resp_o,
    output logic [CNT_W-1:0]    ones_cnt_o
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned EVALS = REPEATS;
`else
    localparam int unsigned EVALS = 1;
`endif
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_e                   state_q, state_d;
    logic [N_STAGES-1:0]      challenge_q, challenge_d;
    logic [SW-1:0]            settle_q, settle_d;
    logic [CNT_W-1:0]         rep_q, rep_d;
    logic [CNT_W-1:0]         ones_q, ones_d, ones_final;
    logic [CNT_W-1:0]         ones_out_q, ones_out_d;
    logic                     resp_q, resp_d;
    logic                     launch_q, launch_d;
    logic                     arb_clr_q, arb_clr_d;
    logic                     arb_q;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sync_bit;
    logic [N_STAGES:0]        top_path, bot_path;

    assign top_path[0] = launch_q;
    assign bot_path[0] = launch_q;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        (* keep = "true", dont_touch = "true" *)
        puf_switch_stage u_stage (
            .top_i (top_path[k]),
            .bot_i (bot_path[k]),
            .c_i   (challenge_q[k]),
            .top_o (top_path[k+1]),
            .bot_o (bot_path[k+1])
        );
    end

    // Bottom path edge captures the top path: 1 means top won the race.
    always_ff @(posedge bot_path[N_STAGES] or posedge arb_clr_q) begin
        if (arb_clr_q) arb_q <= 1'b0;
        else           arb_q <= top_path[N_STAGES];
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], arb_q};
    end
    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        challenge_d = challenge_q;
        settle_d    = settle_q;
        rep_d       = rep_q;
        ones_d      = ones_q;
        ones_out_d  = ones_out_q;
        resp_d      = resp_q;
        ones_final  = ones_q + CNT_W'(sync_bit);
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    challenge_d = challenge_i;
                    ones_d      = '0;
                    rep_d       = '0;
                    settle_d    = '0;
                    state_d     = StArm;
                end
            end
            StArm: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = StFire;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StFire: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StSample: begin
                if (settle_q == SW'(SYNC_STAGES - 1)) begin
                    settle_d = '0;
                    ones_d   = ones_final;
                    if (rep_q == CNT_W'(EVALS - 1)) begin
                        // Results are loaded here so they are valid during the DONE pulse.
                        ones_out_d = ones_final;
`ifdef PUF_MAJORITY_VOTE_EN
                        resp_d = (ones_final > CNT_W'(REPEATS / 2));
`else
                        resp_d = sync_bit;
`endif
                        state_d = StDone;
                    end else begin
                        rep_d   = rep_q + CNT_W'(1);
                        state_d = StArm;
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Launch stays high through SAMPLE so the arbiter holds its decision.
        launch_d  = (state_d == StFire) || (state_d == StSample);
        arb_clr_d = !launch_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            challenge_q <= '0;
            settle_q    <= '0;
            rep_q       <= '0;
            ones_q      <= '0;
            ones_out_q  <= '0;
            resp_q      <= 1'b0;
            launch_q    <= 1'b0;
            arb_clr_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            challenge_q <= challenge_d;
            settle_q    <= settle_d;
            rep_q       <= rep_d;
            ones_q      <= ones_d;
            ones_out_q  <= ones_out_d;
            resp_q      <= resp_d;
            launch_q    <= launch_d;
            arb_clr_q   <= arb_clr_d;
        end
    end

    assign ready_o      = (state_q == StIdle);
    assign resp_valid_o = (state_q == StDone);
    assign resp_o       = resp_q;
    assign ones_cnt_o   = ones_out_q;

endmodule

// File: tb/tb_arbiter_puf_eval.sv
// Self-checking bench for arbiter_puf_eval with a response scoreboard.
module tb_arbiter_puf_eval;

    localparam int N   = 8;
    localparam int S   = 4;
    localparam int R   = 5;
    localparam int CW  = 3;
    localparam int LAT = 2 * S + 2;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int E = R;
`else
    localparam int E = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [N-1:0]  challenge_i;
    logic          ready_o;
    logic          resp_valid_o;
    logic          resp_o;
    logic [CW-1:0] ones_cnt_o;

    logic sw_top, sw_bot, sw_c, sw_top_o, sw_bot_o;

    typedef struct {
        logic          resp;
        logic [CW-1:0] ones;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   n_valid = 0;
    int   a;
    int   nv;

    arbiter_puf_eval #(
        .N_STAGES      (N),
        .SETTLE_CYCLES (S),
        .REPEATS       (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .challenge_i  (challenge_i),
        .ready_o      (ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_o       (resp_o),
        .ones_cnt_o   (ones_cnt_o)
    );

    puf_switch_stage u_sw (
        .top_i (sw_top),
        .bot_i (sw_bot),
        .c_i   (sw_c),
        .top_o (sw_top_o),
        .bot_o (sw_bot_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid_o === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(resp_valid_o), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp", 32'(resp_o), 32'(mon_e.resp));
                check("ones_cnt", 32'(ones_cnt_o), 32'(mon_e.ones));
                check("latency", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [CW-1:0] exp_ones(input logic [4:0] pat);
        logic [CW-1:0] n = '0;
        for (int i = 0; i < E; i++) n = n + CW'(pat[i]);
        return n;
    endfunction

    task automatic force_arb(input logic v);
        if (v) force dut.arb_q = 1'b1;
        else   force dut.arb_q = 1'b0;
    endtask

    // Returns the cycle number of the first ARM cycle.
    task automatic accept(input logic [N-1:0] chal, output int acc);
        @(negedge clk);
        start_i     = 1'b1;
        challenge_i = chal;
        check("ready_before_accept", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        acc         = cyc;
        start_i     = 1'b0;
        challenge_i = ~chal;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic run_pattern(input logic [N-1:0] chal, input logic [4:0] pat);
        int            acc;
        logic [CW-1:0] o;
        accept(chal, acc);
        o = exp_ones(pat);
        sb.push_back('{resp: (o > CW'(E / 2)), ones: o, cyc: acc + E * LAT});
        for (int i = 0; i < E; i++) begin
            force_arb(pat[i]);
            repeat (LAT) @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("ready_in_done", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(ready_o), 32'd1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        challenge_i = '0;
        sw_top      = 1'b1;
        sw_bot      = 1'b0;
        sw_c        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp", 32'(resp_o), 32'd0);
        check("rst_ones", 32'(ones_cnt_o), 32'd0);
        check("rst_launch", 32'(dut.launch_q), 32'd0);
        check("rst_arb_clr", 32'(dut.arb_clr_q), 32'd1);
        rst = 1'b0;

        run_pattern(8'h00, 5'b11111);
        run_pattern(8'hA5, 5'b00000);
        run_pattern(8'h3C, 5'b01101);
        run_pattern(8'hC3, 5'b10100);

        // Busy: start_i and challenge_i toggle while evaluating.
        force_arb(1'b1);
        nv = n_valid;
        accept(8'h96, a);
        sb.push_back('{resp: 1'b1, ones: CW'(E), cyc: a + E * LAT});
        for (int j = 0; j < E * LAT - 1; j++) begin
            start_i     = (j % 2 == 0);
            challenge_i = N'($urandom);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        check("latched_challenge", 32'(dut.challenge_q), 32'h96);
        wait_drain();
        repeat (4) @(posedge clk);
        check("busy_single_valid", n_valid - nv, 1);

        // Reset asserted during FIRE.
        accept(8'h5A, a);
        repeat (S + 1) @(posedge clk);
        #1;
        check("fire_launch", 32'(dut.launch_q), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nv  = n_valid;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_launch", 32'(dut.launch_q), 32'd0);
        check("midrst_valid", 32'(resp_valid_o), 32'd0);
        check("midrst_resp", 32'(resp_o), 32'd0);
        check("midrst_ones", 32'(ones_cnt_o), 32'd0);
        repeat (E * LAT + 5) @(posedge clk);
        #1;
        check("midrst_no_valid", n_valid - nv, 0);
        release dut.arb_q;

        sw_c = 1'b0;
        #1;
        check("stage_c0_top", 32'(sw_top_o), 32'd1);
        check("stage_c0_bot", 32'(sw_bot_o), 32'd0);
        sw_c = 1'b1;
        #1;
        check("stage_c1_top", 32'(sw_top_o), 32'd0);
        check("stage_c1_bot", 32'(sw_bot_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/arbiter_puf_eval.md
# arbiter_puf_eval

Parametrised arbiter-PUF core: an N-stage challenge-controlled switch chain built from 2:1 multiplexer pairs, an arbiter latch at the chain end, and a synchronous evaluation controller. The controller launches the race, waits for settling, samples the arbiter through a synchroniser and returns one response bit per challenge. An optional majority vote over repeated evaluations can be compiled in. The block sits between the challenge source and the response collector in the PUF datapath.

## Interface
- N_STAGES, 64, number of switch stages (≥1)
- SETTLE_CYCLES, 8, clk cycles held in each of ARM and FIRE (≥2)
- REPEATS, 5, evaluations per challenge when voting is compiled in (odd, ≥1)
- CNT_W, $clog2(REPEATS+1), width of ones counter
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request evaluation; accepted only when ready_o=1
- challenge_i  in  N_STAGES  challenge; bit k controls stage k; captured on accept
- ready_o  out  1  high in IDLE
- resp_valid_o  out  1  one-cycle pulse: resp_o/ones_cnt_o updated
- resp_o  out  1  response bit; holds until next resp_valid_o
- ones_cnt_o  out  CNT_W  count of evaluations that sampled 1; holds until next result

## Operation
- Stage k: challenge bit 0 → top→top, bottom→bottom; bit 1 → paths crossed. Both chain inputs driven by a registered launch signal.
- Arbiter: chain-end top path is data, bottom path is the capture edge; arb_q=1 means top arrived first. Held cleared by registered arb_clr.
- FSM states: IDLE, ARM, FIRE, SAMPLE, DONE.
- IDLE: ready_o=1, launch=0, arb_clr=1. start_i=1 → latch challenge, clear ones counter and repeat counter, go ARM.
- ARM: launch=0, arb_clr=1 for SETTLE_CYCLES cycles, then FIRE.
- FIRE: arb_clr=0, launch=1 for SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: 2 cycles while arb_q passes a 2-flop synchroniser; on the second cycle add the synchronised bit to the ones counter. If evaluations remain → ARM, else → DONE.
- DONE: resp_valid_o=1 for one cycle, resp_o/ones_cnt_o loaded; → IDLE.
- start_i outside IDLE is ignored; challenge_i changes after accept are ignored.
- Reset values: state IDLE, ready_o=1, resp_valid_o=0, resp_o=0, ones_cnt_o=0, launch=0, arb_clr=1, counters 0.
- rst mid-operation: return to IDLE on that edge; no resp_valid_o; held results cleared to 0.

## Timing
- Accept at edge ending cycle T (ready_o=1, start_i=1); ARM begins cycle T+1.
- One evaluation = 2·SETTLE_CYCLES+2 cycles.
- resp_valid_o high in cycle T+1+E·(2·SETTLE_CYCLES+2), with E=1 (no voting) or REPEATS (voting).
- ready_o low from T+1 through the DONE cycle; high again the cycle after DONE. The earliest next accept is that cycle.
- SETTLE_CYCLES must exceed the chain propagation delay in clk periods. This is a constraint on the integrator and is not checked in RTL.

## Configuration
- PUF_MAJORITY_VOTE_EN defined: REPEATS evaluations per challenge; resp_o = (ones_cnt > REPEATS/2); ones_cnt_o ranges 0..REPEATS.
- Undefined: REPEATS is ignored and E=1; resp_o = sampled bit; ones_cnt_o ∈ {0,1}.

## Structure
- puf_pkg: FSM state enum, CNT_W helper function, and the constant SYNC_STAGES=2.
- Sub-module puf_switch_stage: two 2:1 muxes sharing one challenge bit. Instantiated N_STAGES times via generate. Mark with keep/dont_touch so the chain is not optimised away.
- Arbiter latch, synchroniser and FSM stay in arbiter_puf_eval.

## Test plan
- Hold rst high 3 cycles → ready_o=1, resp_valid_o=0, resp_o=0, ones_cnt_o=0, launch=0.
- Voting off, SETTLE_CYCLES=4, force arb_q=1, start_i at T with challenge 0 → single resp_valid_o at T+11, resp_o=1, ones_cnt_o=1.
- Voting on, REPEATS=5, SETTLE_CYCLES=4, force arb_q to 1,0,1,1,0 per evaluation → resp_valid_o at T+51, ones_cnt_o=3, resp_o=1. Repeat with 0,0,1,0,1 → ones_cnt_o=2, resp_o=0.
- Pulse start_i and toggle challenge_i every cycle while busy → exactly one resp_valid_o; the latched challenge equals the value at accept.
- Assert rst during FIRE → next cycle ready_o=1, launch=0, no resp_valid_o, outputs 0.
- puf_switch_stage unit test: inputs top=1, bot=0; c=0 → outputs (1,0); c=1 → outputs (0,1).
